// File: rtl/gpr_pkg.sv
// Shared parameters and types for the GPR access arbiter.
//   NUM_GPR : number of implemented registers (legal addresses 0..NUM_GPR-1)
//   DATA_W  : register width
//   ADDR_W  : register address width
package gpr_pkg;

   localparam int unsigned NUM_GPR = 13;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned ADDR_W  = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } gpr_arb_state_t;

   // Unsigned range check at ADDR_W bits
   function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
      return addr < ADDR_W'(NUM_GPR);
   endfunction

endpackage

// File: rtl/gpr_access_arbiter_rr_arb2.sv
// Two-way round-robin pick.
//   req     : per-requester request
//   ptr     : preferred requester this round
//   gnt_idx : chosen requester (meaningful when valid)
//   valid   : at least one request present
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       ptr,
   output logic       gnt_idx,
   output logic       valid
);

   assign valid   = |req;
   // Preferred requester wins if asking, otherwise the other one
   assign gnt_idx = req[ptr] ? ptr : ~ptr;

endmodule

// File: rtl/gpr_access_arbiter.sv
// Shares the GPR register file (write/read port rop1, read port rop2) between
// requester 0 (CPU control) and requester 1 (debug/loader).
//   clk_50, rst          : clock, async active-high reset
//   req/we/addr_a/addr_b/wdata : per-requester access request
//   ack, err             : single-cycle completion pulse and illegal-address flag
//   rdata_a, rdata_b     : read data, held until the next legal read
//   rop1, rop2, GPRLOAD, GPR_data : register file controls
//   GPR_out1, GPR_out2   : register file read data (combinational from rop1/rop2)
module gpr_access_arbiter
   import gpr_pkg::*;
(
   input  logic                   clk_50,
   input  logic                   rst,
   input  logic [1:0]             req,
   input  logic [1:0]             we,
   input  logic [1:0][ADDR_W-1:0] addr_a,
   input  logic [1:0][ADDR_W-1:0] addr_b,
   input  logic [1:0][DATA_W-1:0] wdata,
   output logic [1:0]             ack,
   output logic                   err,
   output logic [DATA_W-1:0]      rdata_a,
   output logic [DATA_W-1:0]      rdata_b,
   output logic [ADDR_W-1:0]      rop1,
   output logic [ADDR_W-1:0]      rop2,
   output logic                   GPRLOAD,
   output logic [DATA_W-1:0]      GPR_data,
   input  logic [DATA_W-1:0]      GPR_out1,
   input  logic [DATA_W-1:0]      GPR_out2
);

   gpr_arb_state_t state_q, state_d;

   logic rr_ptr;
   logic gnt_idx;
   logic arb_valid;
   logic g_q;
   logic we_q;
   logic legal_q;
   logic legal_c;

   rr_arb2 u_rr_arb2 (
      .req     (req),
      .ptr     (rr_ptr),
      .gnt_idx (gnt_idx),
      .valid   (arb_valid)
   );

   // Next state and legality of the request being granted
   always_comb begin
      state_d = state_q;
      legal_c = 1'b0;

      if (we[gnt_idx])
         legal_c = addr_ok(addr_a[gnt_idx]);
      else
         legal_c = addr_ok(addr_a[gnt_idx]) && addr_ok(addr_b[gnt_idx]);

      case (state_q)
         IDLE:    if (arb_valid) state_d = ACCESS;
         ACCESS:  state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk_50 or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Grant latch, register-file drive, response and read capture
   always_ff @(posedge clk_50 or posedge rst) begin
      if (rst) begin
         rr_ptr   <= 1'b0;
         g_q      <= 1'b0;
         we_q     <= 1'b0;
         legal_q  <= 1'b0;
         rop1     <= '0;
         rop2     <= '0;
         GPR_data <= '0;
         GPRLOAD  <= 1'b0;
         ack      <= '0;
         err      <= 1'b0;
         rdata_a  <= '0;
         rdata_b  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (arb_valid) begin
                  g_q      <= gnt_idx;
                  we_q     <= we[gnt_idx];
                  legal_q  <= legal_c;
                  rop1     <= addr_a[gnt_idx];
                  rop2     <= addr_b[gnt_idx];
                  GPR_data <= wdata[gnt_idx];
                  // Strobe is high for exactly the ACCESS cycle
                  GPRLOAD  <= we[gnt_idx] & legal_c;
               end
            end
            ACCESS: begin
               GPRLOAD <= 1'b0;
               ack     <= g_q ? 2'b10 : 2'b01;
               err     <= ~legal_q;
               if (!we_q && legal_q) begin
                  rdata_a <= GPR_out1;
                  rdata_b <= GPR_out2;
               end
            end
            RESP: begin
               ack    <= '0;
               err    <= 1'b0;
               rr_ptr <= ~g_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gpr_access_arbiter.sv
// Directed bench for gpr_access_arbiter with a behavioural 13-entry register file.
module tb_gpr_access_arbiter;

   logic              clk_50 = 1'b0;
   logic              rst    = 1'b0;
   logic [1:0]        req    = '0;
   logic [1:0]        we     = '0;
   logic [1:0][3:0]   addr_a = '0;
   logic [1:0][3:0]   addr_b = '0;
   logic [1:0][31:0]  wdata  = '0;
   logic [1:0]        ack;
   logic              err;
   logic [31:0]       rdata_a, rdata_b;
   logic [3:0]        rop1, rop2;
   logic              GPRLOAD;
   logic [31:0]       GPR_data;
   logic [31:0]       GPR_out1, GPR_out2;

   logic [31:0] regs [13];
   logic [31:0] exp_regs [13];
   logic [31:0] exp_ra, exp_rb;
   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   gpr_access_arbiter dut (
      .clk_50   (clk_50),
      .rst      (rst),
      .req      (req),
      .we       (we),
      .addr_a   (addr_a),
      .addr_b   (addr_b),
      .wdata    (wdata),
      .ack      (ack),
      .err      (err),
      .rdata_a  (rdata_a),
      .rdata_b  (rdata_b),
      .rop1     (rop1),
      .rop2     (rop2),
      .GPRLOAD  (GPRLOAD),
      .GPR_data (GPR_data),
      .GPR_out1 (GPR_out1),
      .GPR_out2 (GPR_out2)
   );

   always #10 clk_50 = ~clk_50;

   always @(posedge clk_50) cyc <= cyc + 1;

   // Register file model, cleared by the same reset
   always_ff @(posedge clk_50 or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 13; i++) regs[i] <= '0;
      end else if (GPRLOAD && rop1 < 4'd13) begin
         regs[rop1] <= GPR_data;
      end
   end

   assign GPR_out1 = (rop1 < 4'd13) ? regs[rop1] : 32'h0;
   assign GPR_out2 = (rop2 < 4'd13) ? regs[rop2] : 32'h0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h) at t=%0t",
                  tag, got, got, exp, exp, $time);
      end
   endtask

   // Issue one access and follow it to its ack (bounded)
   task automatic access(input int r, input logic w, input logic [3:0] a, input logic [3:0] b,
                         input logic [31:0] d, output int lat, output int nload,
                         output logic [3:0] load_addr, output logic e,
                         output logic [31:0] ra, output logic [31:0] rb, output logic got);
      @(negedge clk_50);
      req[r] = 1'b1; we[r] = w; addr_a[r] = a; addr_b[r] = b; wdata[r] = d;
      got = 1'b0; lat = 0; nload = 0; load_addr = '0; e = 1'b0; ra = '0; rb = '0;
      for (int i = 1; i <= 12 && !got; i++) begin
         @(negedge clk_50);
         if (GPRLOAD) begin
            nload++;
            load_addr = rop1;
         end
         if (ack != 2'b00) begin
            check("ack_onehot", 32'(ack), (r == 1) ? 32'd2 : 32'd1);
            got = 1'b1; lat = i; e = err; ra = rdata_a; rb = rdata_b;
            req[r] = 1'b0;
         end
      end
      req[r] = 1'b0;
   endtask

   task automatic do_write(input int r, input logic [3:0] a, input logic [31:0] d);
      int lat, nload; logic [3:0] la; logic e, got; logic [31:0] ra, rb;
      logic legal;
      legal = (a < 4'd13);
      access(r, 1'b1, a, 4'd0, d, lat, nload, la, e, ra, rb, got);
      check("wr_ack_seen", 32'(got), 32'd1);
      check("wr_latency", 32'(lat), 32'd2);
      check("wr_err", 32'(e), legal ? 32'd0 : 32'd1);
      check("wr_load_cycles", 32'(nload), legal ? 32'd1 : 32'd0);
      if (legal) begin
         check("wr_load_addr", 32'(la), 32'(a));
         exp_regs[a] = d;
      end
   endtask

   task automatic do_read(input int r, input logic [3:0] a, input logic [3:0] b);
      int lat, nload; logic [3:0] la; logic e, got; logic [31:0] ra, rb;
      logic legal;
      legal = (a < 4'd13) && (b < 4'd13);
      if (legal) begin
         exp_ra = exp_regs[a];
         exp_rb = exp_regs[b];
      end
      access(r, 1'b0, a, b, 32'hDEAD_BEEF, lat, nload, la, e, ra, rb, got);
      check("rd_ack_seen", 32'(got), 32'd1);
      check("rd_latency", 32'(lat), 32'd2);
      check("rd_err", 32'(e), legal ? 32'd0 : 32'd1);
      check("rd_no_load", 32'(nload), 32'd0);
      check("rd_data_a", ra, exp_ra);
      check("rd_data_b", rb, exp_rb);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_ack, prev_cyc;
      logic stray;
      for (int i = 0; i < 13; i++) exp_regs[i] = '0;
      exp_ra = '0; exp_rb = '0;

      // 1. Reset at 7ns clears all outputs immediately
      #7 rst = 1'b1;
      #1;
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_gprload", 32'(GPRLOAD), 32'd0);
      check("rst_rop1", 32'(rop1), 32'd0);
      check("rst_rop2", 32'(rop2), 32'd0);
      check("rst_rdata_a", rdata_a, 32'd0);
      check("rst_rdata_b", rdata_b, 32'd0);
      check("rst_err", 32'(err), 32'd0);
      repeat (2) @(negedge clk_50);
      rst = 1'b0;
      @(negedge clk_50);
      check("idle_no_ack", 32'(ack), 32'd0);

      // 2. Write then read back the same register
      do_write(0, 4'd3, 32'd250);
      do_read(0, 4'd3, 4'd3);
      check("t2_rdata_a", exp_ra, 32'd250);

      // 4. Illegal write from requester 1, boundary-legal and illegal reads, full readback
      do_write(1, 4'd13, 32'd7);
      do_read(1, 4'd12, 4'd0);
      do_read(1, 4'd3, 4'd14);
      for (int i = 0; i < 13; i++) do_read(1, 4'(i), 4'(12 - i));

      // 3. Both requesters held: strict alternation starting at requester 0
      @(negedge clk_50);
      req = 2'b11; we = 2'b11;
      addr_a[0] = 4'd5; addr_a[1] = 4'd5;
      wdata[0] = 32'd100; wdata[1] = 32'd200;
      n_ack = 0;
      for (int i = 0; i < 40 && n_ack < 4; i++) begin
         @(negedge clk_50);
         if (ack != 2'b00) begin
            check("alt_grant", 32'(ack), (n_ack % 2 == 0) ? 32'd1 : 32'd2);
            n_ack++;
            if (n_ack == 4) req = 2'b00;
         end
      end
      req = 2'b00;
      check("alt_ack_count", 32'(n_ack), 32'd4);
      exp_regs[5] = 32'd200;
      do_read(0, 4'd5, 4'd5);

      // 5. Load r0..r12, then read pairs with req held continuously
      for (int i = 0; i < 13; i++) do_write(1, 4'(i), 32'(100 + i));
      @(negedge clk_50);
      req[0] = 1'b1; we[0] = 1'b0; addr_a[0] = 4'd0; addr_b[0] = 4'd12;
      n_ack = 0; prev_cyc = 0;
      for (int i = 0; i < 80 && n_ack < 13; i++) begin
         @(negedge clk_50);
         if (ack[0]) begin
            check("pair_rdata_a", rdata_a, 32'(100 + n_ack));
            check("pair_rdata_b", rdata_b, 32'(112 - n_ack));
            check("pair_err", 32'(err), 32'd0);
            if (n_ack > 0) check("pair_ack_spacing", 32'(cyc - prev_cyc), 32'd3);
            prev_cyc = cyc;
            n_ack++;
            if (n_ack < 13) begin
               addr_a[0] = 4'(n_ack);
               addr_b[0] = 4'(12 - n_ack);
            end else begin
               req[0] = 1'b0;
            end
         end
      end
      req[0] = 1'b0;
      check("pair_ack_count", 32'(n_ack), 32'd13);
      exp_ra = 32'd112; exp_rb = 32'd100;

      // 6. Reset during ACCESS of a write aborts it
      @(negedge clk_50);
      req[0] = 1'b1; we[0] = 1'b1; addr_a[0] = 4'd7; wdata[0] = 32'd55;
      @(negedge clk_50);
      check("abort_load_before", 32'(GPRLOAD), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("abort_load_dropped", 32'(GPRLOAD), 32'd0);
      check("abort_no_ack", 32'(ack), 32'd0);
      req[0] = 1'b0;
      @(negedge clk_50);
      rst = 1'b0;
      stray = 1'b0;
      repeat (5) begin
         @(negedge clk_50);
         if (ack != 2'b00 || GPRLOAD) stray = 1'b1;
      end
      check("abort_quiet", 32'(stray), 32'd0);
      for (int i = 0; i < 13; i++) exp_regs[i] = '0;
      exp_ra = '0; exp_rb = '0;
      check("abort_rdata_cleared", rdata_a, 32'd0);
      do_read(0, 4'd7, 4'd7);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
